// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings and control word for the RV32I control unit.
// Opcodes, select codes and the per-stage control bundle.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] REG_MEM = 2'd0;
  localparam logic [1:0] REG_ALU = 2'd1;
  localparam logic [1:0] REG_IMM = 2'd2;
  localparam logic [1:0] REG_PC4 = 2'd3;

  localparam logic [1:0] PC_ALU = 2'b01;
  localparam logic [1:0] PC_IMM = 2'b11;

  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       rs1_SEL;
    logic       rs2_SEL;
    logic [3:0] ALU_SEL;
    logic [1:0] reg_SEL;
    logic       mem_WE;
    logic       mem_RE;
    logic       jump;
    logic       branch;
    logic       pc_SEL1;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Instruction decoder: one instruction word to a control word.
// Unknown opcodes decode to an all-zero bubble.
module ctrl_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  imm_sel_o
);

  logic [6:0] op;
  logic [4:0] rd;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_instr;

  assign op   = instr_i[6:0];
  assign rd   = instr_i[11:7];
  assign f3   = instr_i[14:12];
  assign f7b5 = instr_i[30];
  assign unused_instr = ^{instr_i[31], instr_i[29:15]};

  // Opcode class to control fields; x0 destinations never write.
  always_comb begin
    ctrl_o    = '0;
    imm_sel_o = IMM_I;
    ctrl_o.rd = rd;
    unique case (1'b1)
      (op == OPC_LUI): begin
        imm_sel_o      = IMM_U;
        ctrl_o.wr      = 1'b1;
        ctrl_o.reg_SEL = REG_IMM;
      end
      (op == OPC_AUIPC): begin
        imm_sel_o      = IMM_U;
        ctrl_o.wr      = 1'b1;
        ctrl_o.rs1_SEL = 1'b1;
        ctrl_o.rs2_SEL = 1'b1;
        ctrl_o.ALU_SEL = ALU_ADD;
        ctrl_o.reg_SEL = REG_ALU;
      end
      (op == OPC_JAL): begin
        imm_sel_o      = IMM_J;
        ctrl_o.wr      = 1'b1;
        ctrl_o.jump    = 1'b1;
        ctrl_o.pc_SEL1 = 1'b1;
        ctrl_o.reg_SEL = REG_PC4;
      end
      (op == OPC_JALR): begin
        imm_sel_o      = IMM_I;
        ctrl_o.wr      = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rs2_SEL = 1'b1;
        ctrl_o.ALU_SEL = ALU_ADD;
        ctrl_o.jump    = 1'b1;
        ctrl_o.reg_SEL = REG_PC4;
      end
      (op == OPC_BR): begin
        imm_sel_o      = IMM_B;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.ALU_SEL = ALU_SUB;
        ctrl_o.branch  = 1'b1;
        ctrl_o.pc_SEL1 = 1'b1;
      end
      (op == OPC_LOAD): begin
        imm_sel_o      = IMM_I;
        ctrl_o.wr      = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rs2_SEL = 1'b1;
        ctrl_o.ALU_SEL = ALU_ADD;
        ctrl_o.mem_RE  = 1'b1;
        ctrl_o.reg_SEL = REG_MEM;
      end
      (op == OPC_STORE): begin
        imm_sel_o      = IMM_S;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.rs2_SEL = 1'b1;
        ctrl_o.ALU_SEL = ALU_ADD;
        ctrl_o.mem_WE  = 1'b1;
      end
      (op == OPC_OPIMM): begin
        imm_sel_o      = IMM_I;
        ctrl_o.wr      = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rs2_SEL = 1'b1;
        ctrl_o.ALU_SEL = {(f3 == 3'b101) & f7b5, f3};
        ctrl_o.reg_SEL = REG_ALU;
      end
      (op == OPC_OP): begin
        ctrl_o.wr      = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.ALU_SEL = {f7b5, f3};
        ctrl_o.reg_SEL = REG_ALU;
      end
      default: ;
    endcase
    if (rd == 5'd0) ctrl_o.wr = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Control and hazard unit for the five-stage RV32I datapath.
// Carries control words D->WB, stalls on RAW, redirects from M.
module pipe_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_D,
  input  logic [XLEN-1:0] Instr,
  input  logic            br_taken_E,
  output logic [2:0]      imm_SEL,
  output logic            rs1_SEL,
  output logic            rs2_SEL,
  output logic [3:0]      ALU_SEL,
  output logic [1:0]      pc_SEL,
  output logic            mem_WE,
  output logic            mem_RE,
  output logic [1:0]      reg_SEL,
  output logic            reg_WE,
  output logic            stall_F,
  output logic            stall_D,
  output logic            stall_E,
  output logic            stall_M,
  output logic            stall_WB,
  output logic            flush_F,
  output logic            flush_D,
  output logic            flush_E,
  output logic            flush_M,
  output logic            flush_WB
);

  logic [XLEN-1:0] instr_D;
  logic            v_D, v_E, v_M, v_WB;
  logic            taken_M, redirect_q;
  ctrl_t           ctrl_dec, ctrl_E, ctrl_M, ctrl_WB;
  logic [2:0]      imm_dec;
  logic [4:0]      rs1_D, rs2_D;
  logic            hz_rs1, hz_rs2, hazard;
  logic            redirect_M, stall_fd;
  logic            unused_wb;

  ctrl_decode u_dec (
    .instr_i   (instr_D[31:0]),
    .ctrl_o    (ctrl_dec),
    .imm_sel_o (imm_dec)
  );

  assign rs1_D = instr_D[19:15];
  assign rs2_D = instr_D[24:20];
  assign unused_wb = ^ctrl_WB;

  // RAW against E/M writers; a redirect in M overrides it.
  always_comb begin
    hz_rs1 = ctrl_dec.use_rs1 && (rs1_D != 5'd0) &&
             ((v_E && ctrl_E.wr && (ctrl_E.rd == rs1_D)) ||
              (v_M && ctrl_M.wr && (ctrl_M.rd == rs1_D)));
    hz_rs2 = ctrl_dec.use_rs2 && (rs2_D != 5'd0) &&
             ((v_E && ctrl_E.wr && (ctrl_E.rd == rs2_D)) ||
              (v_M && ctrl_M.wr && (ctrl_M.rd == rs2_D)));
    hazard     = v_D && (hz_rs1 || hz_rs2);
    redirect_M = v_M && (ctrl_M.jump || (ctrl_M.branch && taken_M));
    stall_fd   = hazard && !redirect_M;
  end

  // D register: hold on stall, kill on redirect.
  always_ff @(posedge clk or posedge reset_D) begin
    if (reset_D) begin
      v_D     <= 1'b0;
      instr_D <= '0;
    end else if (redirect_M) begin
      v_D     <= 1'b0;
    end else if (!stall_fd) begin
      v_D     <= 1'b1;
      instr_D <= Instr;
    end
  end

  // E register: bubble on hazard, kill on redirect.
  always_ff @(posedge clk or posedge reset_D) begin
    if (reset_D) begin
      v_E    <= 1'b0;
      ctrl_E <= '0;
    end else if (redirect_M || hazard) begin
      v_E    <= 1'b0;
      ctrl_E <= '0;
    end else begin
      v_E    <= v_D;
      ctrl_E <= ctrl_dec;
    end
  end

  // M and WB registers; the redirecting instruction itself retires.
  always_ff @(posedge clk or posedge reset_D) begin
    if (reset_D) begin
      v_M     <= 1'b0;
      ctrl_M  <= '0;
      taken_M <= 1'b0;
      v_WB    <= 1'b0;
      ctrl_WB <= '0;
    end else begin
      v_M     <= v_E && !redirect_M;
      ctrl_M  <= ctrl_E;
      taken_M <= br_taken_E;
      v_WB    <= v_M;
      ctrl_WB <= ctrl_M;
    end
  end

  // Registered redirect drives the glitch-free flushes.
  always_ff @(posedge clk or posedge reset_D) begin
    if (reset_D) redirect_q <= 1'b0;
    else         redirect_q <= redirect_M;
  end

  assign imm_SEL  = v_D ? imm_dec : 3'd0;
  assign rs1_SEL  = v_E && ctrl_E.rs1_SEL;
  assign rs2_SEL  = v_E && ctrl_E.rs2_SEL;
  assign ALU_SEL  = v_E ? ctrl_E.ALU_SEL : 4'd0;
  assign pc_SEL   = redirect_M ? {ctrl_M.pc_SEL1, 1'b1} : 2'b00;
  assign mem_WE   = v_M && ctrl_M.mem_WE;
  assign mem_RE   = v_M && ctrl_M.mem_RE;
  assign reg_SEL  = v_WB ? ctrl_WB.reg_SEL : 2'd0;
  assign reg_WE   = v_WB && ctrl_WB.wr;
  assign stall_F  = stall_fd;
  assign stall_D  = stall_fd;
  assign stall_E  = 1'b0;
  assign stall_M  = 1'b0;
  assign stall_WB = 1'b0;
  assign flush_F  = 1'b0;
  assign flush_D  = 1'b0;
  assign flush_E  = redirect_q;
  assign flush_M  = redirect_q;
  assign flush_WB = 1'b0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/redirect scenarios
// plus a random stream against an instruction-slot model.
module tb_pipe_ctrl;

  localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17;
  localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67;
  localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03;
  localparam logic [6:0] O_ST = 7'h23, O_OPI = 7'h13;
  localparam logic [6:0] O_OP = 7'h33;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_D;
  logic [31:0] Instr;
  logic br_taken_E;
  logic [2:0] imm_SEL;
  logic rs1_SEL, rs2_SEL;
  logic [3:0] ALU_SEL;
  logic [1:0] pc_SEL;
  logic mem_WE, mem_RE;
  logic [1:0] reg_SEL;
  logic reg_WE;
  logic stall_F, stall_D, stall_E, stall_M, stall_WB;
  logic flush_F, flush_D, flush_E, flush_M, flush_WB;
  logic [25:0] all_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset_D(reset_D), .Instr(Instr),
    .br_taken_E(br_taken_E), .imm_SEL(imm_SEL),
    .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .ALU_SEL(ALU_SEL),
    .pc_SEL(pc_SEL), .mem_WE(mem_WE), .mem_RE(mem_RE),
    .reg_SEL(reg_SEL), .reg_WE(reg_WE),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .stall_M(stall_M), .stall_WB(stall_WB),
    .flush_F(flush_F), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .flush_WB(flush_WB)
  );

  always #5 clk = ~clk;

  assign all_o = {imm_SEL, rs1_SEL, rs2_SEL, ALU_SEL, pc_SEL,
                  mem_WE, mem_RE, reg_SEL, reg_WE,
                  stall_F, stall_D, stall_E, stall_M, stall_WB,
                  flush_F, flush_D, flush_E, flush_M, flush_WB};

  function automatic logic [31:0] addi(input logic [4:0] rd,
      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, O_OPI};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, O_OP};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1,
      input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'd0, O_BR};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd,
      input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, O_JALR};
  endfunction

  // ---- reference rules, per instruction ----
  function automatic logic [4:0] dest_of(input logic [31:0] i);
    case (i[6:0])
      O_LUI, O_AUIPC, O_JAL, O_JALR, O_LD, O_OPI, O_OP:
        return i[11:7];
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic [4:0] src1_of(input logic [31:0] i);
    case (i[6:0])
      O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP: return i[19:15];
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic [4:0] src2_of(input logic [31:0] i);
    case (i[6:0])
      O_BR, O_ST, O_OP: return i[24:20];
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic [2:0] exp_imm(input logic [31:0] i);
    case (i[6:0])
      O_LUI, O_AUIPC: return 3'd3;
      O_JAL: return 3'd4;
      O_BR: return 3'd2;
      O_ST: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [3:0] exp_alu(input logic [31:0] i);
    case (i[6:0])
      O_OP: return {i[30], i[14:12]};
      O_OPI: return {(i[14:12] == 3'd5) ? i[30] : 1'b0, i[14:12]};
      O_BR: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic exp_rs2imm(input logic [31:0] i);
    case (i[6:0])
      O_AUIPC, O_JALR, O_LD, O_ST, O_OPI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [1:0] exp_rsel(input logic [31:0] i);
    case (i[6:0])
      O_AUIPC, O_OPI, O_OP: return 2'd1;
      O_LUI: return 2'd2;
      O_JAL, O_JALR: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    int k;
    k = $urandom_range(0, 19);
    if (k < 4) op = O_OPI;
    else if (k < 8) op = O_OP;
    else if (k == 8) op = O_LUI;
    else if (k == 9) op = O_AUIPC;
    else if (k == 10) op = O_JAL;
    else if (k == 11) op = O_JALR;
    else if (k < 14) op = O_BR;
    else if (k < 16) op = O_LD;
    else if (k < 18) op = O_ST;
    else if (k == 18) op = 7'h0F;
    else op = 7'h73;
    return {7'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  // ---- directed fetch driver ----
  logic [31:0] prog [0:31];
  int pc, tgt;
  logic taken_drv;
  logic tr_st [0:63];
  logic tr_we [0:63];
  logic tr_mw [0:63];
  logic tr_fe [0:63];
  logic tr_fm [0:63];
  logic [1:0] tr_pc [0:63];
  logic [1:0] tr_rs [0:63];

  task automatic fill_nops();
    for (int i = 0; i < 32; i++) prog[i] = NOP;
    taken_drv = 1'b0;
    tgt = 16;
  endtask

  task automatic do_reset();
    reset_D = 1'b1;
    Instr = NOP;
    br_taken_E = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_D = 1'b0;
    pc = 0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      Instr = prog[pc % 32];
      br_taken_E = taken_drv;
      @(negedge clk);
      tr_st[c] = stall_F;
      tr_we[c] = reg_WE;
      tr_mw[c] = mem_WE;
      tr_fe[c] = flush_E;
      tr_fm[c] = flush_M;
      tr_pc[c] = pc_SEL;
      tr_rs[c] = reg_SEL;
      if (pc_SEL[0]) pc = tgt;
      else if (!stall_F) pc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_D = 1'b1;
    br_taken_E = 1'b1;
    for (int c = 0; c < 3; c++) begin
      Instr = $urandom;
      @(negedge clk);
      checks++;
      if (all_o !== 26'd0) begin
        errors++;
        $display("FAIL reset_outputs got %h want 0", all_o);
      end
    end
    fill_nops();
    do_reset();
    Instr = NOP;
    @(posedge clk);
    #1;
    checks++;
    if (dut.v_D !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_vD got %b want 1", dut.v_D);
    end
  endtask

  task automatic test_nop_stream();
    int nw, ns;
    fill_nops();
    do_reset();
    run(10);
    nw = 0;
    ns = 0;
    for (int c = 0; c < 10; c++) begin
      nw += int'(tr_we[c]);
      ns += int'(tr_st[c]);
    end
    checks++;
    if (nw != 0 || ns != 0) begin
      errors++;
      $display("FAIL nop_stream got we=%0d st=%0d want 0/0", nw, ns);
    end
  endtask

  task automatic test_distance(input int gap, input int want);
    int ns, a, b, nw;
    fill_nops();
    prog[0] = addi(5'd1, 5'd0, 12'd5);
    prog[1 + gap] = add(5'd2, 5'd1, (gap == 0) ? 5'd1 : 5'd0);
    do_reset();
    run(16);
    ns = 0;
    nw = 0;
    a = -1;
    b = -1;
    for (int c = 0; c < 16; c++) begin
      ns += int'(tr_st[c]);
      if (tr_we[c] === 1'b1) begin
        nw++;
        if (a < 0) a = c;
        else b = c;
      end
    end
    checks++;
    if (ns != want) begin
      errors++;
      $display("FAIL dist%0d_stalls got %0d want %0d",
               gap + 1, ns, want);
    end
    checks++;
    if (nw != 2 || (b - a) != (gap + 1 + want)) begin
      errors++;
      $display("FAIL dist%0d_wb got n=%0d gap=%0d want 2/%0d",
               gap + 1, nw, b - a, gap + 1 + want);
    end
    if (gap == 0) begin
      checks++;
      if (a < 0 || tr_rs[a] !== 2'd1) begin
        errors++;
        $display("FAIL dist1_regsel got %0d want 1",
                 (a < 0) ? -1 : int'(tr_rs[a]));
      end
    end
  endtask

  task automatic test_branch();
    int r, nr, nw, nm;
    fill_nops();
    prog[0] = beq(5'd0, 5'd0);
    prog[1] = addi(5'd1, 5'd0, 12'd1);
    prog[2] = {7'b0, 5'd0, 5'd0, 3'b010, 5'd0, O_ST};
    prog[3] = addi(5'd2, 5'd0, 12'd2);
    prog[10] = addi(5'd3, 5'd0, 12'd7);
    tgt = 10;
    taken_drv = 1'b1;
    do_reset();
    run(14);
    r = -1;
    nr = 0;
    nw = 0;
    nm = 0;
    for (int c = 0; c < 14; c++) begin
      if (tr_pc[c] !== 2'b00) begin
        nr++;
        r = c;
      end
      nw += int'(tr_we[c]);
      nm += int'(tr_mw[c]);
    end
    checks++;
    if (nr != 1 || tr_pc[r] !== 2'b11) begin
      errors++;
      $display("FAIL branch_pcsel got n=%0d want 1 of 3", nr);
    end
    checks++;
    if (r < 0 || tr_fe[r + 1] !== 1'b1 || tr_fm[r + 1] !== 1'b1) begin
      errors++;
      $display("FAIL branch_flush got r=%0d want flushes after", r);
    end
    checks++;
    if (nw != 1 || nm != 0) begin
      errors++;
      $display("FAIL branch_kill got we=%0d mw=%0d want 1/0", nw, nm);
    end
  endtask

  task automatic test_jalr();
    int r, nw;
    fill_nops();
    prog[0] = jalr(5'd1, 5'd5);
    tgt = 12;
    do_reset();
    run(12);
    r = -1;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      if (tr_pc[c] !== 2'b00 && r < 0) r = c;
      nw += int'(tr_we[c]);
    end
    checks++;
    if (r < 0 || tr_pc[r] !== 2'b01) begin
      errors++;
      $display("FAIL jalr_pcsel got r=%0d want 01", r);
    end
    checks++;
    if (r < 0 || tr_we[r + 1] !== 1'b1 || tr_rs[r + 1] !== 2'd3
        || nw != 1) begin
      errors++;
      $display("FAIL jalr_wb got nw=%0d want reg_SEL 3 once", nw);
    end
  endtask

  task automatic test_hazard_redirect();
    int r, nw;
    fill_nops();
    prog[0] = beq(5'd0, 5'd0);
    prog[1] = addi(5'd1, 5'd0, 12'd5);
    prog[2] = add(5'd2, 5'd1, 5'd1);
    prog[10] = addi(5'd3, 5'd0, 12'd7);
    tgt = 10;
    taken_drv = 1'b1;
    do_reset();
    run(14);
    r = -1;
    nw = 0;
    for (int c = 0; c < 14; c++) begin
      if (tr_pc[c] !== 2'b00 && r < 0) r = c;
      nw += int'(tr_we[c]);
    end
    checks++;
    if (r != 3 || tr_st[3] !== 1'b0) begin
      errors++;
      $display("FAIL hz_redirect got r=%0d st=%b want 3/0",
               r, tr_st[3]);
    end
    checks++;
    if (nw != 1) begin
      errors++;
      $display("FAIL hz_redirect_target got we=%0d want 1", nw);
    end
  endtask

  task automatic test_reset_mid_stall();
    bit seen;
    fill_nops();
    prog[0] = addi(5'd1, 5'd0, 12'd5);
    prog[1] = add(5'd2, 5'd1, 5'd1);
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      Instr = prog[pc % 32];
      @(negedge clk);
      if (stall_F === 1'b1) seen = 1'b1;
      else begin
        pc++;
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midstall_timeout got no stall want stall");
    end
    #2;
    reset_D = 1'b1;
    #1;
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL midstall_reset got %h want 0", all_o);
    end
    @(posedge clk);
    #1;
    reset_D = 1'b0;
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic        tk;
  } slot_t;

  task automatic test_random();
    slot_t sD, sE, sM, sW;
    logic redq, red, hz, tk, hs;
    logic [31:0] fi;
    logic [4:0] dE, dM, s1, s2;
    logic [1:0] pcs;
    logic [25:0] exp;
    int nprint;
    fill_nops();
    do_reset();
    sD = '0;
    sE = '0;
    sM = '0;
    sW = '0;
    redq = 1'b0;
    nprint = 0;
    fi = rnd_instr();
    for (int c = 0; c < 400; c++) begin
      tk = 1'($urandom);
      Instr = fi;
      br_taken_E = tk;
      @(negedge clk);
      dE = sE.v ? dest_of(sE.ins) : 5'd0;
      dM = sM.v ? dest_of(sM.ins) : 5'd0;
      s1 = sD.v ? src1_of(sD.ins) : 5'd0;
      s2 = sD.v ? src2_of(sD.ins) : 5'd0;
      hz = (s1 != 0 && (s1 == dE || s1 == dM)) ||
           (s2 != 0 && (s2 == dE || s2 == dM));
      red = sM.v && (sM.ins[6:0] == O_JAL || sM.ins[6:0] == O_JALR ||
                     (sM.ins[6:0] == O_BR && sM.tk));
      pcs = !red ? 2'b00 : (sM.ins[6:0] == O_JALR) ? 2'b01 : 2'b11;
      hs = hz && !red;
      exp = {sD.v ? exp_imm(sD.ins) : 3'd0,
             sE.v && sE.ins[6:0] == O_AUIPC,
             sE.v && exp_rs2imm(sE.ins),
             sE.v ? exp_alu(sE.ins) : 4'd0,
             pcs,
             sM.v && sM.ins[6:0] == O_ST,
             sM.v && sM.ins[6:0] == O_LD,
             sW.v ? exp_rsel(sW.ins) : 2'd0,
             sW.v && dest_of(sW.ins) != 5'd0,
             hs, hs, 3'b000,
             2'b00, redq, redq, 1'b0};
      checks++;
      if (all_o !== exp) begin
        errors++;
        if (nprint < 10)
          $display("FAIL random cyc %0d got %h want %h", c, all_o, exp);
        nprint++;
      end
      @(posedge clk);
      #1;
      sW = sM;
      if (red) begin
        sM.v = 1'b0;
        sE.v = 1'b0;
        sD.v = 1'b0;
        fi = rnd_instr();
      end else begin
        sM.v = sE.v;
        sM.ins = sE.ins;
        sM.tk = tk;
        if (hz) sE.v = 1'b0;
        else begin
          sE = sD;
          sD.v = 1'b1;
          sD.ins = fi;
          sD.tk = 1'b0;
          fi = rnd_instr();
        end
      end
      redq = red;
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_distance(0, 2);
    test_distance(1, 1);
    test_distance(2, 0);
    test_branch();
    test_jalr();
    test_hazard_redirect();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
